// File: rtl/m_fetch_queue_pkg.sv
// m_fetch_queue_pkg: shared fetch/decode types and defaults for the fetch queue.
package m_fetch_queue_pkg;
  localparam int DEPTH_DEF = 2;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pair_t;
endpackage

// File: rtl/m_fetch_queue_ctrl.sv
// m_fetch_queue_ctrl: pointers, occupancy count and push/pop/flush handshake flags.
module m_fetch_queue_ctrl #(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_in_valid,
  input  logic          i_out_ready,
  input  logic          i_flush,
  output logic          o_in_ready,
  output logic          o_out_valid,
  output logic          o_push,
  output logic [AW-1:0] o_wr_ptr,
  output logic [AW-1:0] o_rd_ptr
);
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop;
  assign o_in_ready  = r_count != CW'(DEPTH);
  assign o_out_valid = r_count != '0;
  assign o_push      = i_in_valid & o_in_ready & !i_flush;
  assign w_pop       = o_out_valid & i_out_ready & !i_flush;
  assign o_wr_ptr    = r_wr_ptr;
  assign o_rd_ptr    = r_rd_ptr;
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset)
    if (!reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (o_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(o_push) - CW'(w_pop);
    end
endmodule

// File: rtl/m_fetch_queue.sv
// m_fetch_queue: fetch-to-decode instruction FIFO with flush and NOP on empty.
// FETCH_QUEUE_STATS_EN adds saturating full/empty/flush counters.
module m_fetch_queue
  import m_fetch_queue_pkg::*;
#(
  parameter int          DEPTH     = DEPTH_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  input  logic        flush,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0] stat_full_cycles,
  output logic [31:0] stat_empty_cycles,
  output logic [15:0] stat_flushes
`endif
);
  fetch_pair_t   r_mem [DEPTH];
  logic          w_push;
  logic [AW-1:0] w_wr_ptr, w_rd_ptr;
  m_fetch_queue_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .i_in_valid (in_valid),
    .i_out_ready(out_ready),
    .i_flush    (flush),
    .o_in_ready (in_ready),
    .o_out_valid(out_valid),
    .o_push     (w_push),
    .o_wr_ptr   (w_wr_ptr),
    .o_rd_ptr   (w_rd_ptr)
  );
  // Storage needs no reset: out_valid masks stale entries.
  always_ff @(posedge clk)
    if (w_push) r_mem[w_wr_ptr] <= '{pc: in_pc, instr: in_instr};
  assign out_pc    = out_valid ? r_mem[w_rd_ptr].pc : '0;
  assign out_instr = out_valid ? r_mem[w_rd_ptr].instr : NOP_INSTR;
`ifdef FETCH_QUEUE_STATS_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      stat_full_cycles  <= '0;
      stat_empty_cycles <= '0;
      stat_flushes      <= '0;
    end else begin
      if (!in_ready && stat_full_cycles != '1) stat_full_cycles <= stat_full_cycles + 1'b1;
      if (!out_valid && out_ready && stat_empty_cycles != '1) stat_empty_cycles <= stat_empty_cycles + 1'b1;
      if (flush && stat_flushes != '1) stat_flushes <= stat_flushes + 1'b1;
    end
`endif
endmodule

// File: tb/tb_m_fetch_queue.sv
// tb_m_fetch_queue: directed self-checking bench for m_fetch_queue.
module tb_m_fetch_queue;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] in_pc = '0, in_instr = '0;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_instr;
  int          n_tests = 0, n_fail = 0;
`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stat_full_cycles, stat_empty_cycles;
  logic [15:0] stat_flushes;
`endif
  always #5 clk = ~clk;
  m_fetch_queue dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_pc    (in_pc),
    .in_instr (in_instr),
    .in_ready (in_ready),
    .flush    (flush),
    .out_valid(out_valid),
    .out_pc   (out_pc),
    .out_instr(out_instr),
    .out_ready(out_ready)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .stat_full_cycles (stat_full_cycles),
    .stat_empty_cycles(stat_empty_cycles),
    .stat_flushes     (stat_flushes)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    in_valid = v;
    in_pc    = pc;
    in_instr = ins;
  endtask
  initial begin
    drive(1'b1, 32'h40, 32'h99);
    repeat (3) step();
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    reset = 1'b1;
    drive(1'b0, 0, 0);
    step();
    chk("post_rst_empty", {31'b0, out_valid}, 32'd0);
    drive(1'b1, 32'h0, 32'hA);
    step();
    chk("fill1_valid", {31'b0, out_valid}, 32'd1);
    chk("fill1_instr", out_instr, 32'hA);
    chk("fill1_ready", {31'b0, in_ready}, 32'd1);
    drive(1'b1, 32'h4, 32'hB);
    step();
    chk("fill2_ready", {31'b0, in_ready}, 32'd0);
    chk("fill2_pc", out_pc, 32'h0);
    drive(1'b1, 32'h8, 32'hC);
    step();
    chk("full_hold_pc", out_pc, 32'h0);
    chk("full_hold_ready", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    step();
    chk("fullpop_pc", out_pc, 32'h4);
    chk("fullpop_instr", out_instr, 32'hB);
    chk("fullpop_ready", {31'b0, in_ready}, 32'd1);
    step();
    chk("order_pc", out_pc, 32'h8);
    chk("order_instr", out_instr, 32'hC);
    drive(1'b0, 0, 0);
    step();
    chk("drain_valid", {31'b0, out_valid}, 32'd0);
    chk("drain_nop", out_instr, 32'h0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), 32'h1000 + 32'(i));
      step();
      chk("stream_pc", out_pc, 32'h200 + 32'(4 * i));
      chk("stream_instr", out_instr, 32'h1000 + 32'(i));
      chk("stream_ready", {31'b0, in_ready}, 32'd1);
    end
    drive(1'b0, 0, 0);
    step();
    chk("stream_end", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;
    drive(1'b1, 32'h10, 32'h70);
    step();
    drive(1'b1, 32'h14, 32'h71);
    step();
    chk("pre_flush_full", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    flush = 1'b1;
    drive(1'b1, 32'h18, 32'h72);
    step();
    flush = 1'b0;
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_nop", out_instr, 32'h0);
    chk("flush_pc", out_pc, 32'h0);
    chk("flush_ready", {31'b0, in_ready}, 32'd1);
    drive(1'b1, 32'h100, 32'h55);
    step();
    chk("redir_pc", out_pc, 32'h100);
    chk("redir_instr", out_instr, 32'h55);
    out_ready = 1'b0;
    drive(1'b1, 32'h104, 32'h56);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("async_rst_ready", {31'b0, in_ready}, 32'd1);
    step();
    reset = 1'b1;
    drive(1'b0, 0, 0);
    step();
    chk("async_rst_after", {31'b0, out_valid}, 32'd0);
`ifdef FETCH_QUEUE_STATS_EN
    reset = 1'b0;
    #1;
    chk("stat_rst_full", stat_full_cycles, 32'd0);
    reset = 1'b1;
    out_ready = 1'b0;
    drive(1'b1, 32'h0, 32'h1);
    step();
    drive(1'b1, 32'h4, 32'h2);
    step();
    drive(1'b0, 0, 0);
    repeat (4) step();
    flush = 1'b1;
    step();
    step();
    flush = 1'b0;
    chk("stat_full", stat_full_cycles, 32'd5);
    chk("stat_flushes", {16'b0, stat_flushes}, 32'd2);
    chk("stat_empty", stat_empty_cycles, 32'd0);
    reset = 1'b0;
    #1;
    chk("stat_clr_full", stat_full_cycles, 32'd0);
    chk("stat_clr_flush", {16'b0, stat_flushes}, 32'd0);
    reset = 1'b1;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
